// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit feeding HI/LO, with a start/busy/done handshake.
// Optional MULTU/DIVU support is enabled by defining MULT_DIV_UNSIGNED_EN.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, m_q;
  logic             op_div_q, neg_q, rneg_q, divz_q;
  logic             busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             uns;
  logic             accept_d;
  logic             a_neg_d, b_neg_d, b_zero_d;
  logic [WIDTH-1:0] a_mag_d, b_mag_d;
  logic [WIDTH:0]   mul_sum_d, div_shift_d;
  logic [WIDTH-1:0] div_diff_d;
  logic             div_ge_d;
  logic [WIDTH-1:0] iter_hi_d, iter_lo_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0] fin_hi_d, fin_lo_d;

`ifdef MULT_DIV_UNSIGNED_EN
  assign uns = op_unsigned;
`else
  logic unused_op_unsigned;
  assign uns = 1'b0;
  assign unused_op_unsigned = op_unsigned;
`endif

  always_comb begin
    accept_d = start && (state_q != CALC);
    a_neg_d  = !uns && a[WIDTH-1];
    b_neg_d  = !uns && b[WIDTH-1];
    a_mag_d  = a_neg_d ? -a : a;
    b_mag_d  = b_neg_d ? -b : b;
    b_zero_d = (b == {WIDTH{1'b0}});

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
    mul_sum_d   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? m_q : {WIDTH{1'b0}})};
    div_shift_d = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge_d    = div_shift_d >= {1'b0, m_q};
    div_diff_d  = div_shift_d[WIDTH-1:0] - m_q;
    if (op_div_q) begin
      iter_hi_d = div_ge_d ? div_diff_d : div_shift_d[WIDTH-1:0];
      iter_lo_d = {acc_lo_q[WIDTH-2:0], div_ge_d};
    end else begin
      iter_hi_d = mul_sum_d[WIDTH:1];
      iter_lo_d = {mul_sum_d[0], acc_lo_q[WIDTH-1:1]};
    end

    prod_d = {acc_hi_q, acc_lo_q};
    if (neg_q) prod_d = -prod_d;
    if (op_div_q) begin
      fin_hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
      fin_lo_d = neg_q ? -acc_lo_q : acc_lo_q;
    end else begin
      fin_hi_d = prod_d[2*WIDTH-1:WIDTH];
      fin_lo_d = prod_d[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      m_q        <= '0;
      op_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      divz_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= (state_q == FINISH);
      // Results commit as FINISH is left; a zero divide leaves hi/lo untouched
      if (state_q == FINISH) begin
        div_zero_q <= divz_q;
        if (!divz_q) begin
          hi_q <= fin_hi_d;
          lo_q <= fin_lo_d;
        end
      end else if (accept_d) begin
        div_zero_q <= 1'b0;
      end

      case (state_q)
        CALC: begin
          acc_hi_q <= iter_hi_d;
          acc_lo_q <= iter_lo_d;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= FINISH;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          if (accept_d) begin
            op_div_q <= op_div;
            m_q      <= b_mag_d;
            acc_hi_q <= '0;
            acc_lo_q <= a_mag_d;
            neg_q    <= a_neg_d ^ b_neg_d;
            rneg_q   <= a_neg_d;
            divz_q   <= op_div && b_zero_d;
            cnt_q    <= CNT_W'(WIDTH);
            state_q  <= (op_div && b_zero_d) ? FINISH : CALC;
            busy_q   <= !(op_div && b_zero_d);
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed handshake/latency cases plus
// randomized multiplies and divides checked against a plain-arithmetic model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, start, op_div, op_unsigned;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int vectors = 0;
  int errors  = 0;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op_div(op_div),
    .op_unsigned(op_unsigned), .a(a), .b(b), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  // Reference: full-width product, truncating quotient, dividend-signed remainder
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic div, input logic uns,
                                output logic [W-1:0] rhi, output logic [W-1:0] rlo);
    longint la, lb, p, q, r;
    logic   eff_uns;
`ifdef MULT_DIV_UNSIGNED_EN
    eff_uns = uns;
`else
    eff_uns = 1'b0;
`endif
    la = eff_uns ? longint'({32'b0, ma}) : longint'($signed(ma));
    lb = eff_uns ? longint'({32'b0, mb}) : longint'($signed(mb));
    if (div) begin
      q = la / lb;
      r = la % lb;
      rlo = q[W-1:0];
      rhi = r[W-1:0];
    end else begin
      p = la * lb;
      rlo = p[W-1:0];
      rhi = p[2*W-1:W];
    end
  endfunction

  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tdiv, input logic tuns);
    @(negedge clock);
    a = ta; b = tb_v; op_div = tdiv; op_unsigned = tuns; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen; bounded
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (lat <= 200) begin
      if (busy) bcnt++;
      if (done) break;
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tdiv, input logic tuns, output int lat, output int bcnt);
    launch(ta, tb_v, tdiv, tuns);
    wait_done(lat, bcnt);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op_div = 1'b0; op_unsigned = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({busy, done, div_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got busy/done/dz=%b want 000", {busy, done, div_zero});
    end
    vectors++;
    if ({hi, lo} !== 64'h0) begin
      errors++; $display("FAIL reset_hilo got %h_%h want 0_0", hi, lo);
    end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_mult;
    int lat, bcnt;
    logic [W-1:0] ehi, elo, ra, rb;
    run_op(32'd7, -32'sd3, 1'b0, 1'b0, lat, bcnt);
    vectors++;
    if (lat !== W + 1) begin errors++; $display("FAIL mul_latency got %0d want %0d", lat, W + 1); end
    vectors++;
    if (bcnt !== W) begin errors++; $display("FAIL mul_busy_cycles got %0d want %0d", bcnt, W); end
    vectors++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL mul_7x-3 got %h_%h want ffffffff_ffffffeb", hi, lo);
    end
    for (int i = 0; i < 16; i++) begin
      ra = (i % 4 == 0) ? 32'h80000000 : $urandom;
      rb = (i % 5 == 0) ? 32'hFFFFFFFF : $urandom;
      run_op(ra, rb, 1'b0, 1'(i % 3 == 0), lat, bcnt);
      model(ra, rb, 1'b0, 1'(i % 3 == 0), ehi, elo);
      vectors++;
      if (hi !== ehi || lo !== elo || lat !== W + 1) begin
        errors++; $display("FAIL mul_rand %h*%h got %h_%h lat %0d want %h_%h lat %0d",
                           ra, rb, hi, lo, lat, ehi, elo, W + 1);
      end
    end
  endtask

  task automatic test_div;
    int lat, bcnt;
    logic [W-1:0] ehi, elo, ra, rb;
    run_op(-32'sd7, 32'd2, 1'b1, 1'b0, lat, bcnt);
    vectors++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD || lat !== W + 1) begin
      errors++; $display("FAIL div_-7/2 got %h_%h lat %0d want ffffffff_fffffffd lat %0d", hi, lo, lat, W + 1);
    end
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, lat, bcnt);
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h80000000) begin
      errors++; $display("FAIL div_min/-1 got %h_%h want 00000000_80000000", hi, lo);
    end
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? ($urandom & 32'h0000FFFF) : $urandom;
      if (i % 4 == 1) rb = -($urandom_range(9, 1));
      if (rb == 0) rb = 32'd1;
      run_op(ra, rb, 1'b1, 1'(i % 3 == 0), lat, bcnt);
      model(ra, rb, 1'b1, 1'(i % 3 == 0), ehi, elo);
      vectors++;
      if (hi !== ehi || lo !== elo || lat !== W + 1 || div_zero !== 1'b0) begin
        errors++; $display("FAIL div_rand %h/%h got %h_%h lat %0d dz %b want %h_%h lat %0d dz 0",
                           ra, rb, hi, lo, lat, div_zero, ehi, elo, W + 1);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, bcnt;
    run_op(32'd5, 32'd6, 1'b0, 1'b0, lat, bcnt);
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h1E) begin
      errors++; $display("FAIL dz_preload got %h_%h want 00000000_0000001e", hi, lo);
    end
    run_op(32'd9, 32'd0, 1'b1, 1'b0, lat, bcnt);
    vectors++;
    if (lat !== 1 || div_zero !== 1'b1) begin
      errors++; $display("FAIL dz_flag got lat %0d dz %b want lat 1 dz 1", lat, div_zero);
    end
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h1E) begin
      errors++; $display("FAIL dz_hold got %h_%h want 00000000_0000001e", hi, lo);
    end
    launch(32'd3, 32'd4, 1'b0, 1'b0);
    vectors++;
    if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear got %b want 0", div_zero); end
    wait_done(lat, bcnt);
    vectors++;
    if (lo !== 32'hC || lat !== W + 1) begin
      errors++; $display("FAIL dz_after got lo %h lat %0d want 0000000c lat %0d", lo, lat, W + 1);
    end
  endtask

  task automatic test_ignore_start;
    int lat, bcnt;
    launch(32'd11, 32'd13, 1'b0, 1'b0);
    repeat (5) begin @(posedge clock); #1; end
    a = 32'd100; b = 32'd200; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    vectors++;
    if (lo !== 32'd143 || hi !== 32'h0 || lat + 6 !== W + 1) begin
      errors++; $display("FAIL ignore_start got %h_%h lat %0d want 00000000_0000008f lat %0d",
                         hi, lo, lat + 6, W + 1);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt, n;
    logic [W-1:0] ra, rb, ehi, elo;
    ra = $urandom; rb = $urandom;
    launch(ra, rb, 1'b0, 1'b0);
    n = 0;
    while (busy && n < 100) begin @(posedge clock); #1; n++; end
    a = -32'sd50; b = 32'd7; op_div = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    model(ra, rb, 1'b0, 1'b0, ehi, elo);
    vectors++;
    if (done !== 1'b1 || hi !== ehi || lo !== elo) begin
      errors++; $display("FAIL b2b_first got done %b %h_%h want 1 %h_%h", done, hi, lo, ehi, elo);
    end
    @(posedge clock); #1;
    wait_done(lat, bcnt);
    vectors++;
    if (lat + 1 !== W + 1 || lo !== 32'hFFFFFFF9 || hi !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL b2b_second got %h_%h gap %0d want ffffffff_fffffff9 gap %0d",
                         hi, lo, lat + 1, W + 1);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, dcnt;
    run_op(32'd7, -32'sd3, 1'b0, 1'b0, lat, bcnt);
    launch(32'd123, 32'd456, 1'b0, 1'b0);
    repeat (10) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, div_zero} !== 3'b000 || {hi, lo} !== 64'h0) begin
      errors++; $display("FAIL reset_mid got busy/done/dz=%b %h_%h want 000 0_0",
                         {busy, done, div_zero}, hi, lo);
    end
    @(negedge clock); @(negedge clock); reset = 1'b0;
    dcnt = 0;
    repeat (40) begin @(posedge clock); #1; if (done) dcnt++; end
    vectors++;
    if (dcnt !== 0) begin errors++; $display("FAIL reset_no_done got %0d pulses want 0", dcnt); end
    run_op(32'd3, 32'd4, 1'b0, 1'b0, lat, bcnt);
    vectors++;
    if (lo !== 32'hC || hi !== 32'h0) begin
      errors++; $display("FAIL reset_fresh got %h_%h want 00000000_0000000c", hi, lo);
    end
  endtask

  task automatic test_unsigned;
    int lat, bcnt;
    logic [W-1:0] mhi, mlo, dhi, dlo;
`ifdef MULT_DIV_UNSIGNED_EN
    mhi = 32'h1; mlo = 32'hFFFFFFFE; dhi = 32'h1; dlo = 32'h7FFFFFFF;
`else
    mhi = 32'hFFFFFFFF; mlo = 32'hFFFFFFFE; dhi = 32'hFFFFFFFF; dlo = 32'h0;
`endif
    run_op(32'hFFFFFFFF, 32'd2, 1'b0, 1'b1, lat, bcnt);
    vectors++;
    if (hi !== mhi || lo !== mlo || lat !== W + 1) begin
      errors++; $display("FAIL multu got %h_%h lat %0d want %h_%h lat %0d", hi, lo, lat, mhi, mlo, W + 1);
    end
    run_op(32'hFFFFFFFF, 32'd2, 1'b1, 1'b1, lat, bcnt);
    vectors++;
    if (hi !== dhi || lo !== dlo || lat !== W + 1) begin
      errors++; $display("FAIL divu got %h_%h lat %0d want %h_%h lat %0d", hi, lo, lat, dhi, dlo, W + 1);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_unsigned();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
